// File: rtl/uart_wb_pkg.sv
// Shared widths, FSM state type and byte-lane helper for the UART Wishbone master.
package uart_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  // The UART sits on a 32-bit bus; the low address bits pick the byte lane.
  function automatic logic [SEL_W-1:0] lane_sel(input logic [ADDR_W-1:0] addr);
    return SEL_W'(1) << addr[1:0];
  endfunction

endpackage

// File: rtl/uart_wb_if.sv
// Command/response handshake plus Wishbone classic signals towards the UART.
// Handshakes: a beat moves on a rising edge where valid & ready are both 1;
// once raised, valid and its payload hold until that edge.
interface uart_wb_if;
  import uart_wb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] wb_addr_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_we_o;
  logic              wb_stb_o;
  logic              wb_cyc_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           wb_addr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           wb_addr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

endinterface

// File: rtl/uart_wb_timeout.sv
// Bus-cycle watchdog: counts un-acked strobe cycles and flags the final allowed one.
module uart_wb_timeout
  import uart_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expiry on count TIMEOUT_CYC-1 gives exactly TIMEOUT_CYC strobe cycles.
  assign expired = (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_wb_master.sv
// Turns single command beats into Wishbone classic accesses to a UART, with timeout abort.
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_i,
  uart_wb_if.master bus,
  output state_e    state_dbg
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              in_bus;
  logic              expired;

  assign in_bus = (state_q == BUS);

  uart_wb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (!in_bus),
    .enable  (in_bus && !bus.wb_ack_i),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = BUS;
      BUS:     if (bus.wb_ack_i || expired) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.cmd_valid) begin
        addr_q  <= bus.cmd_addr;
        we_q    <= bus.cmd_we;
        wdata_q <= bus.cmd_wdata;
      end
      // Ack is tested first so it wins over a coincident timeout.
      if (in_bus && bus.wb_ack_i) begin
        rdata_q <= we_q ? '0 : bus.wb_dat_i;
        err_q   <= 1'b0;
      end else if (in_bus && expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign bus.wb_cyc_o  = in_bus;
  assign bus.wb_stb_o  = in_bus;
  assign bus.wb_we_o   = in_bus && we_q;
  assign bus.wb_addr_o = in_bus ? addr_q : '0;
  assign bus.wb_sel_o  = in_bus ? lane_sel(addr_q) : '0;
  assign bus.wb_dat_o  = (in_bus && we_q) ? wdata_q : '0;

  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Randomized bench for uart_wb_master with a transaction-level response model.
module tb_uart_wb_master;
  import uart_wb_pkg::*;

  localparam int T = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_wb_if bus_if();
  state_e    state_dbg;

  uart_wb_master #(.TIMEOUT_CYC(T)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus_if.master),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];  // {err, rdata} per issued command

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wb_ack_i  = 1'b0;
    bus_if.wb_dat_i  = '0;
  endtask

  // ack_dly: BUS cycle index (0 = first) carrying the ack; >= T means never ack.
  task automatic run_txn(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                         input int ack_dly, input logic [7:0] slave_data, input int rsp_wait);
    int         cycles;
    int         exp_cycles;
    bit         acked;
    logic [8:0] exp_rsp;
    logic [3:0] exp_sel;
    acked      = (ack_dly < T);
    exp_cycles = acked ? ack_dly + 1 : T;
    exp_sel    = 4'b0001 << addr[1:0];
    exp_q.push_back({!acked, (acked && !we) ? slave_data : 8'h00});

    check("cmd_ready_idle", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = 5'($urandom);
    bus_if.cmd_wdata = 8'($urandom);
    bus_if.cmd_we    = 1'($urandom);

    cycles = 0;
    while (bus_if.wb_stb_o === 1'b1 && cycles < T + 4) begin
      check("wb_cyc", 32'(bus_if.wb_cyc_o), 32'd1);
      check("wb_addr", 32'(bus_if.wb_addr_o), 32'(addr));
      check("wb_sel", 32'(bus_if.wb_sel_o), 32'(exp_sel));
      check("wb_we", 32'(bus_if.wb_we_o), 32'(we));
      check("wb_dat", 32'(bus_if.wb_dat_o), we ? 32'(wdata) : 32'd0);
      check("cmd_ready_busy", 32'(bus_if.cmd_ready), 32'd0);
      if (acked && cycles == ack_dly) begin
        bus_if.wb_ack_i = 1'b1;
        bus_if.wb_dat_i = slave_data;
      end else begin
        bus_if.wb_ack_i = 1'b0;
        bus_if.wb_dat_i = 8'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    bus_if.wb_ack_i = 1'b0;

    check("stb_cycles", 32'(cycles), 32'(exp_cycles));
    check("wb_cyc_after", 32'(bus_if.wb_cyc_o), 32'd0);
    exp_rsp = exp_q.pop_front();
    check("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    check("rsp_err", 32'(bus_if.rsp_err), 32'(exp_rsp[8]));
    check("rsp_rdata", 32'(bus_if.rsp_rdata), 32'(exp_rsp[7:0]));

    // Backpressure: stray commands and acks must not disturb a pending response.
    for (int i = 0; i < rsp_wait; i++) begin
      bus_if.cmd_valid = 1'b1;
      bus_if.wb_ack_i  = 1'($urandom);
      bus_if.wb_dat_i  = 8'($urandom);
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      check("bp_rsp_err", 32'(bus_if.rsp_err), 32'(exp_rsp[8]));
      check("bp_rsp_rdata", 32'(bus_if.rsp_rdata), 32'(exp_rsp[7:0]));
      check("bp_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      check("bp_no_cyc", 32'(bus_if.wb_cyc_o), 32'd0);
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.wb_ack_i  = 1'b0;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    check("rsp_done", 32'(bus_if.rsp_valid), 32'd0);
    check("cmd_ready_back", 32'(bus_if.cmd_ready), 32'd1);
  endtask

  task automatic reset_mid_bus();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = 1'b1;
    bus_if.cmd_addr  = 5'd6;
    bus_if.cmd_wdata = 8'hC3;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    check("rst_pre_stb", 32'(bus_if.wb_stb_o), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_cyc", 32'(bus_if.wb_cyc_o), 32'd0);
    check("rst_stb", 32'(bus_if.wb_stb_o), 32'd0);
    check("rst_sel", 32'(bus_if.wb_sel_o), 32'd0);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    repeat (T + 2) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check("reset_cyc", 32'(bus_if.wb_cyc_o), 32'd0);
    check("reset_stb", 32'(bus_if.wb_stb_o), 32'd0);
    check("reset_we", 32'(bus_if.wb_we_o), 32'd0);
    check("reset_addr", 32'(bus_if.wb_addr_o), 32'd0);
    check("reset_sel", 32'(bus_if.wb_sel_o), 32'd0);
    check("reset_dat", 32'(bus_if.wb_dat_o), 32'd0);
    check("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("reset_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    check("reset_err", 32'(bus_if.rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 5'd3, 8'h83, 2, 8'h00, 0);      // write, ack after 2 cycles
    run_txn(1'b0, 5'd5, 8'h00, 0, 8'h60, 0);      // read, best-case latency
    run_txn(1'b0, 5'd7, 8'h00, T, 8'hAA, 1);      // timeout
    run_txn(1'b0, 5'd2, 8'h00, T - 1, 8'h5C, 0);  // ack on final timeout cycle
    run_txn(1'b1, 5'd9, 8'h42, 1, 8'h00, 5);      // response backpressure
    reset_mid_bus();

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 5'($urandom_range(0, 31)), 8'($urandom),
              int'($urandom_range(0, T + 2)), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as in the codebase: wb_clk_i (clock) and wb_rst_i (reset).
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum number of cycles with wb_stb_o high before the access is aborted (legal range 2..255).
REQ-003 wb_clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 wb_rst_i  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_we  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  5  UART register address.
REQ-009 cmd_wdata  in  8  write data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_rdata  out  8  read data; 0 for writes and for aborts.
REQ-013 rsp_err  out  1  1 = access aborted by timeout.
REQ-014 wb_addr_o  out  5  Wishbone address, to UART wb_addr_i.
REQ-015 wb_sel_o  out  4  byte select, to UART wb_sel_i.
REQ-016 wb_dat_o  out  8  write data, to UART wb_dat_i.
REQ-017 wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  Wishbone classic controls.
REQ-018 wb_dat_i  in  8  read data, from UART wb_dat_o.
REQ-019 wb_ack_i  in  1  acknowledge, from UART wb_ack_o.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUS, RESP.
REQ-021 cmd_ready SHALL be 1 only in IDLE, and SHALL be driven directly from the state register.
REQ-022 On cmd_valid&cmd_ready at edge N, the block SHALL register addr/we/wdata and enter BUS; wb_cyc_o=wb_stb_o=1 SHALL be visible from cycle N+1.
REQ-023 wb_sel_o SHALL be 4'b0001 << cmd_addr[1:0] during BUS and 0 otherwise; wb_dat_o SHALL be 0 during reads.
REQ-024 wb_addr_o, wb_we_o, wb_dat_o and wb_sel_o SHALL stay stable for the whole BUS state.
REQ-025 In BUS, wb_ack_i=1 at edge K SHALL capture wb_dat_i into rsp_rdata (reads only), set rsp_err=0, deassert cyc/stb from K+1, and enter RESP.
REQ-026 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-027 When the counter reaches TIMEOUT_CYC-1 without ack, the block SHALL drop cyc/stb, set rsp_err=1 and rsp_rdata=0, and enter RESP.
REQ-028 If ack and timeout coincide, ack SHALL win and rsp_err SHALL be 0.
REQ-029 wb_ack_i outside BUS SHALL be ignored.
REQ-030 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata and rsp_err SHALL be held stable until rsp_valid&rsp_ready.
REQ-031 On rsp_valid&rsp_ready, the block SHALL return to IDLE; the minimum command-to-command spacing is 3 cycles.
REQ-032 Best-case latency SHALL be: command at edge N, ack at edge N+1, rsp_valid visible at N+2.

Reset
REQ-033 On wb_rst_i=1 at an edge, the state SHALL become IDLE and all outputs SHALL take these values: cyc/stb/we=0, addr/sel/dat=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, cmd_ready=1 in the following cycle.
REQ-034 Reset SHALL take priority over every other event, including during BUS, where cyc/stb drop at the next edge with no response issued.

Structure
REQ-035 Package uart_wb_pkg SHALL hold the ADDR_W=5, DATA_W=8 and SEL_W=4 constants and the state enum typedef.
REQ-036 The timeout counter SHALL be a sub-module uart_wb_timeout with ports clear, enable and expired.

Verification
REQ-037 The bench SHALL cover a write: cmd addr=3, wdata=8'h83, ack after 2 cycles -> wb_sel_o=4'b1000, wb_dat_o=8'h83, wb_we_o=1, then rsp_valid with err=0 and rdata=0.
REQ-038 The bench SHALL cover a read: cmd addr=5, with wb_dat_i=8'h60 and ack on the first BUS cycle -> rsp_rdata=8'h60 at N+2, wb_sel_o=4'b0010.
REQ-039 The bench SHALL cover a timeout: no ack with TIMEOUT_CYC=16 -> stb high for exactly 16 cycles, then rsp_err=1 and rdata=0.
REQ-040 The bench SHALL cover a simultaneous event: ack on the final timeout cycle -> rsp_err=0 and data captured.
REQ-041 The bench SHALL cover backpressure: rsp_ready held 0 for 5 cycles -> rsp fields stable, cmd_ready=0, and a new cmd_valid is not accepted.
REQ-042 The bench SHALL cover reset mid-BUS: wb_rst_i=1 for 1 cycle -> cyc/stb=0 next cycle, no rsp_valid, cmd_ready=1.
